// File: rtl/period_scheduler.sv
// period_scheduler: walks a class-period table against time of day and runs the end-of-period seat-clear handshake.
// Optional macro PERIOD_WARN_EN adds the registered ending-soon warning.
module period_scheduler #(
  parameter int NUM_PERIODS = 8,
  parameter int WARN_MIN = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sched_en,
  input  logic        tick,
  input  logic [4:0]  hour,
  input  logic [5:0]  minute,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_idx,
  input  logic [10:0] cfg_start,
  input  logic [5:0]  cfg_len,
  input  logic        clear_ack,
  output logic        clear_req,
  output logic        period_active,
  output logic [2:0]  period_idx,
  output logic        warn,
  output logic        cfg_err
);
  localparam int IW = (NUM_PERIODS > 1) ? $clog2(NUM_PERIODS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_PERIODS - 1);
  typedef enum logic [2:0] {IDLE, WAIT, ACTIVE, CLEAR, DONE} state_t;
  state_t state, state_d;
  logic [IW-1:0] idx, idx_d;
  logic [5:0] elapsed, elapsed_d;
  logic [10:0] start_tab [NUM_PERIODS];
  logic [5:0] len_tab [NUM_PERIODS];
  logic [10:0] now, cur_start;
  logic [5:0] cur_len;
  logic [11:0] cur_end;
  logic last, wr_hit;
  assign now = {hour, 6'b0} - {4'b0, hour, 2'b0} + {5'b0, minute};
  assign cur_start = start_tab[idx];
  assign cur_len = len_tab[idx];
  assign cur_end = {1'b0, cur_start} + {6'b0, cur_len};
  assign last = idx == LAST;
  assign wr_hit = cfg_we && cfg_idx[IW-1:0] == idx && (state == ACTIVE || state == CLEAR);
  assign clear_req = state == CLEAR;
  assign period_active = state == ACTIVE;
  assign period_idx = 3'(idx);
  always_comb begin
    state_d = state;
    idx_d = idx;
    elapsed_d = elapsed;
    case (state)
      IDLE: if (sched_en) begin
        state_d = WAIT;
        idx_d = '0;
      end
      WAIT: if (!sched_en) state_d = IDLE;
      else if (cur_len == 6'd0 || {1'b0, now} >= cur_end) begin
        state_d = last ? DONE : WAIT;
        idx_d = last ? idx : idx + IW'(1);
      end else if (now >= cur_start) begin
        state_d = ACTIVE;
        elapsed_d = 6'(now - cur_start);
      end
      ACTIVE: if (!sched_en) state_d = IDLE;
      else if (elapsed == cur_len) state_d = CLEAR;
      else if (tick) elapsed_d = elapsed + 6'd1;
      // the handshake always completes before a disable takes effect
      CLEAR: if (clear_ack) begin
        state_d = !sched_en ? IDLE : last ? DONE : WAIT;
        idx_d = (!sched_en || last) ? idx : idx + IW'(1);
      end
      DONE: if (!sched_en) state_d = IDLE;
      else if (tick && now == 11'd0) begin
        state_d = WAIT;
        idx_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      elapsed <= '0;
      cfg_err <= 1'b0;
      for (int i = 0; i < NUM_PERIODS; i++) begin
        start_tab[i] <= '0;
        len_tab[i] <= '0;
      end
    end else begin
      state <= state_d;
      idx <= idx_d;
      elapsed <= elapsed_d;
      cfg_err <= wr_hit;
      if (cfg_we && !wr_hit) begin
        start_tab[cfg_idx[IW-1:0]] <= cfg_start;
        len_tab[cfg_idx[IW-1:0]] <= cfg_len;
      end
    end
  end
`ifdef PERIOD_WARN_EN
  // computed from next state so warn lines up with the elapsed count it reflects
  logic [5:0] remain_d;
  assign remain_d = cur_len - elapsed_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) warn <= 1'b0;
    else warn <= state_d == ACTIVE && {1'b0, remain_d} <= 7'(WARN_MIN);
  end
`else
  assign warn = 1'b0;
`endif
endmodule

// File: doc/period_scheduler.md
PERIOD_SCHEDULER -- requirements
Module: period_scheduler

Interface
REQ-001 SHALL have parameter NUM_PERIODS, default 8, number of class-period table entries (power of two, 2..8).
REQ-002 SHALL have parameter WARN_MIN, default 5, minutes-before-end warning threshold (1..63).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port sched_en  input  1  scheduler enable, level.
REQ-006 SHALL have port tick  input  1  one-cycle strobe, minute counter advanced.
REQ-007 SHALL have port hour  input  5  current hour, 0..23.
REQ-008 SHALL have port minute  input  6  current minute, 0..59.
REQ-009 SHALL have port cfg_we  input  1  table write strobe.
REQ-010 SHALL have port cfg_idx  input  3  entry index, only log2(NUM_PERIODS) LSBs used.
REQ-011 SHALL have port cfg_start  input  11  period start, minutes-of-day 0..1439.
REQ-012 SHALL have port cfg_len  input  6  period length in minutes, 0 = entry disabled.
REQ-013 SHALL have port clear_ack  input  1  seat-table clear acknowledge.
REQ-014 SHALL have port clear_req  output  1  request seat-table clear at period end.
REQ-015 SHALL have port period_active  output  1  a period is in progress.
REQ-016 SHALL have port period_idx  output  3  current/next entry index.
REQ-017 SHALL have port warn  output  1  period ending soon.
REQ-018 SHALL have port cfg_err  output  1  one-cycle pulse, rejected table write.

Function
REQ-019 SHALL compute now = hour*60 + minute as 11-bit unsigned, combinationally, re-evaluated every cycle.
REQ-020 SHALL use states IDLE, WAIT, ACTIVE, CLEAR, DONE.
REQ-021 IDLE: sched_en=1 -> WAIT with period_idx=0 next cycle.
REQ-022 WAIT: len==0 or now >= start+len (12-bit sum) -> skip, period_idx+1 (one entry per cycle), or DONE if last entry.
REQ-023 WAIT: else if now >= start -> ACTIVE, elapsed loaded with now-start, period_active=1 from next cycle.
REQ-024 ACTIVE: elapsed increments by 1 on each tick; when elapsed equals len -> CLEAR, period_active=0, clear_req=1 from next cycle.
REQ-025 CLEAR: clear_req SHALL hold high until clear_ack sampled high; next cycle clear_req=0 and go to WAIT with period_idx+1, or DONE if last entry.
REQ-026 clear_ack while not in CLEAR SHALL be ignored.
REQ-027 DONE: on tick with now==0 (midnight wrap) -> WAIT, period_idx=0.
REQ-028 sched_en=0 in WAIT, ACTIVE or DONE -> IDLE next cycle, period_active=0; in CLEAR the handshake SHALL complete first, then IDLE.
REQ-029 cfg_we SHALL write entry cfg_idx in one cycle, except a write to period_idx while in ACTIVE or CLEAR is dropped and cfg_err pulses next cycle.
REQ-030 A write in the same cycle as a WAIT compare on the same entry SHALL take effect for the compare in the following cycle.
REQ-031 period_idx SHALL never exceed NUM_PERIODS-1; in DONE it holds NUM_PERIODS-1.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, period_idx=0, elapsed=0, clear_req=0, period_active=0, warn=0, cfg_err=0, all table lengths 0.
REQ-033 Reset mid-CLEAR SHALL drop clear_req without waiting for clear_ack.

Configuration
REQ-034 With macro PERIOD_WARN_EN defined, warn SHALL be 1 while ACTIVE and (len - elapsed) <= WARN_MIN, else 0, registered.
REQ-035 Without PERIOD_WARN_EN, warn SHALL be constant 0 and no warn compare logic synthesised.

Verification
REQ-036 Entry0 start=480 len=50; drive now 479->480 -> period_active=1 next cycle; 50 ticks later clear_req=1; clear_ack after 3 cycles -> clear_req=0, period_idx=1.
REQ-037 sched_en rises at now=600 with entry0 {480,50}, entry1 {590,50} -> entry0 skipped, ACTIVE on entry1 with elapsed=10.
REQ-038 All entries len=0 -> WAIT walks to DONE in NUM_PERIODS cycles; tick at now=0 -> WAIT, period_idx=0.
REQ-039 cfg_we to active entry mid-period -> cfg_err pulse 1 cycle, table unchanged, period ends on original length.
REQ-040 PERIOD_WARN_EN, len=50, WARN_MIN=5 -> warn rises at elapsed=45, falls on entry to CLEAR; rst_n low in CLEAR -> clear_req=0 immediately.
